// File: rtl/dcache_refill_ctrl_if.sv
// Bundle of the refill engine's request, memory and fill signals.
// The master side is the cache plus memory; the slave side is the refill engine.
interface dcache_refill_ctrl_if;
  logic         req_valid;
  logic [1:0]   req_mode;
  logic [31:0]  req_addr;
  logic [108:0] req_set;

  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_we;
  logic [31:0]  mem_req_addr;
  logic [31:0]  mem_req_wdata;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rsp_rdata;

  logic         fill_valid;
  logic [108:0] fill_line;
  logic [31:0]  fill_addr;
  logic         busy;
  logic         err;

  modport master (
    output req_valid, req_mode, req_addr, req_set,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  fill_valid, fill_line, fill_addr, busy, err
  );

  modport slave (
    input  req_valid, req_mode, req_addr, req_set,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output fill_valid, fill_line, fill_addr, busy, err
  );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// Miss/refill engine for the 2-way data cache: optional dirty-victim writeback,
// single-word fetch, and a rebuilt 109-bit set image delivered as a one-cycle fill.
module dcache_refill_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          VICTIM_INIT    = 1'b0
) (
  input logic                 CLK,
  input logic                 RESET,
  dcache_refill_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WB, RD, WAIT, FILL} state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  state_t       state_q, state_d;
  logic [15:0]  cnt_q;
  logic         ptr_q;
  logic         vic_q, use_ptr_q;
  logic [31:0]  addr_q, rdata_q;
  logic [108:0] set_q;
  logic         req_ok, wb_needed, vic_sel, vic_ptr, timeout;

  // Returns {victim chosen by the round-robin pointer, victim way}.
  function automatic logic [1:0] pick_victim(input logic [108:0] s, input logic [19:0] tag,
                                             input logic ptr);
    if (!s[53])                 return 2'b00;
    else if (!s[108])           return 2'b01;
    else if (s[51:32] == tag)   return 2'b00;
    else if (s[105:86] == tag)  return 2'b01;
    else                        return {1'b1, ptr};
  endfunction

  // Victim way becomes valid/clean with the new tag and word; way1's aux bit
  // is cleared only when way1 is the one being replaced.
  function automatic logic [108:0] rebuild(input logic [108:0] s, input logic way,
                                           input logic [19:0] tag, input logic [31:0] d);
    logic [108:0] r;
    r = s;
    if (way) r[108:54] = {1'b1, 1'b0, 1'b0, tag, d};
    else     r[53:0]   = {1'b1, 1'b0, tag, d};
    return r;
  endfunction

  assign req_ok             = bus.req_valid && (bus.req_mode == 2'b01 || bus.req_mode == 2'b10);
  assign {vic_ptr, vic_sel} = pick_victim(bus.req_set, bus.req_addr[31:12], ptr_q);
  assign wb_needed          = (bus.req_mode == 2'b10) &&
                              (vic_sel ? bus.req_set[107] : bus.req_set[52]);

  always_comb begin
    state_d           = state_q;
    timeout           = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_wdata = '0;
    bus.fill_valid    = 1'b0;
    bus.fill_line     = '0;
    bus.fill_addr     = '0;
    bus.busy          = (state_q != IDLE);
    case (state_q)
      IDLE: if (req_ok) state_d = wb_needed ? WB : RD;
      WB: begin
        if (cnt_q == TMO) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          bus.mem_req_valid = 1'b1;
          bus.mem_req_we    = 1'b1;
          bus.mem_req_addr  = {(vic_q ? set_q[105:86] : set_q[51:32]), addr_q[11:2], 2'b00};
          bus.mem_req_wdata = vic_q ? set_q[85:54] : set_q[31:0];
          if (bus.mem_req_ready) state_d = RD;
        end
      end
      RD: begin
        if (cnt_q == TMO) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          bus.mem_req_valid = 1'b1;
          bus.mem_req_addr  = {addr_q[31:2], 2'b00};
          if (bus.mem_req_ready) state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == TMO) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else if (bus.mem_rsp_valid) begin
          state_d = FILL;
        end
      end
      FILL: begin
        bus.fill_valid = 1'b1;
        bus.fill_line  = rebuild(set_q, vic_q, addr_q[31:12], rdata_q);
        bus.fill_addr  = addr_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    bus.err = timeout;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= VICTIM_INIT;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q == WB || state_q == RD || state_q == WAIT)
        cnt_q <= cnt_q + 16'd1;
      if (state_q == FILL && use_ptr_q)
        ptr_q <= ~ptr_q;
    end
  end

  // Request image and response word; only ever read in states that follow their capture.
  always_ff @(posedge CLK) begin
    if (state_q == IDLE && req_ok) begin
      addr_q    <= bus.req_addr;
      set_q     <= bus.req_set;
      vic_q     <= vic_sel;
      use_ptr_q <= vic_ptr;
    end
    if (state_q == WAIT && bus.mem_rsp_valid)
      rdata_q <= bus.mem_rsp_rdata;
  end
endmodule

// File: doc/dcache_refill_ctrl.md
Name: dcache_refill_ctrl

Overview:
- Miss/refill engine directly downstream of the 2-way data cache's compare stage.
- Captures a miss request: mode, miss address, and the 109-bit set image.
- Writes back a dirty victim word if required, fetches the missing word over a valid/ready memory port, and returns a rebuilt 109-bit set image with a one-cycle fill pulse that the cache writes into its set RAM.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for any single memory handshake or response before abort. Range 1..65535.
- VICTIM_INIT, 0: reset value of the round-robin victim pointer (0 = way0, 1 = way1).

Ports:
- CLK  in  1  clock
- RESET  in  1  reset
- req_valid  in  1  miss request from cache CMP stage (level; sampled only in IDLE)
- req_mode  in  2  2'b01 read-fill; 2'b10 writeback-then-fill; other values ignored
- req_addr  in  32  miss address
- req_set  in  109  set image; way1 = [108] V, [107] D, [106] aux, [105:86] tag, [85:54] data; way0 = [53] V, [52] D, [51:32] tag, [31:0] data
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write
- mem_req_addr  out  32  word address, bits [1:0] = 0
- mem_req_wdata  out  32  writeback data
- mem_rsp_valid  in  1  read data valid
- mem_rsp_rdata  in  32  read data
- fill_valid  out  1  one-cycle pulse; fill_line/fill_addr valid
- fill_line  out  109  rebuilt set image
- fill_addr  out  32  address of the filled word
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: asynchronous, active-low, on RESET; clock CLK.
- Reset values: all outputs 0, state IDLE, timeout counter 0, victim pointer = VICTIM_INIT.
- States: IDLE, WB, RD, WAIT, FILL.
- IDLE: when req_valid and req_mode ∈ {01, 10}, latch req_addr and req_set, select victim, move next cycle. Mode 10 with victim D=1 → WB; otherwise → RD. Other modes are ignored.
- Victim select, first match wins:
  - way0 invalid → way0
  - way1 invalid → way1
  - way whose tag equals req_addr[31:12] → that way (stale-tag refresh)
  - otherwise the victim pointer
- Victim pointer toggles on every FILL that used it.
- WB:
  - mem_req_valid=1, we=1, addr={victim_tag, addr[11:2], 2'b00}, wdata=victim data.
  - On valid&&ready → RD.
  - Outputs stay stable while ready is low.
- RD:
  - mem_req_valid=1, we=0, addr={req_addr[31:2], 2'b00}.
  - On valid&&ready → WAIT.
  - A mem_rsp_valid in the same cycle as the handshake is ignored; the response is taken in WAIT.
- WAIT: on mem_rsp_valid, capture rdata → FILL.
- FILL: one cycle; fill_valid=1 → IDLE.
  - Victim way: V=1, D=0, tag=req_addr[31:12], data=rdata.
  - Other way: copied bit-exact from the latch. If the victim is way1, [106] is cleared; if the victim is way0, [106] is preserved.
  - fill_addr = latched req_addr.
- Latency with zero-wait memory (ready=1, response the cycle after accept): read-fill 3 cycles req→fill_valid; writeback-fill 4 cycles.
- Timeout:
  - Counter resets on each state entry and increments in WB, RD and WAIT.
  - On reaching TIMEOUT_CYCLES: err pulse, drop mem_req_valid, → IDLE, no fill, victim pointer unchanged.
- Requests arriving while busy are not queued. The cache re-asserts on retry.
- mem_rsp_valid outside WAIT is ignored.
- Reset mid-operation: immediate return to IDLE, with no pulses on the following cycle.

Test Plan:
- Read-fill, way0 invalid: req_mode=01, addr=0x1234_5678, set=0, zero-wait memory returning 0xDEAD_BEEF → fill_valid at cycle 3; fill_line[53]=1, [52]=0, [51:32]=0x12345, [31:0]=0xDEADBEEF, [108:54]=0; fill_addr=0x1234_5678.
- Dirty writeback: both ways valid; way0 dirty with tag 0xAAAAA and data 0x1111_1111; pointer=0; mode=10; addr=0x0000_0ABC → one write at addr 0xAAAA_AABC with wdata 0x1111_1111, then a read at 0x0000_0ABC; fill in 4 cycles; way1 bits unchanged; pointer becomes 1.
- Backpressure: mem_req_ready low for 5 cycles in WB and 3 cycles in RD → addr/wdata/we stable throughout; fill_valid exactly once; total 12 cycles.
- Timeout: TIMEOUT_CYCLES=8, no response in WAIT → err pulse once 8 cycles after entering WAIT; busy drops next cycle; no fill_valid.
- Ignore while busy, and invalid mode: req_valid held high for 20 cycles, plus req_mode=00 in IDLE → exactly one transaction; mode 00 produces no memory traffic.
- Async reset in WAIT: RESET low mid-wait, then a late mem_rsp_valid → outputs 0 immediately; late response ignored; no fill.
